// File: rtl/raster_pkg.sv
// Shared definitions for the triangle raster front end.
// Holds the fp16 constants, the scanner state enum and the default coordinate width.
package raster_pkg;

    localparam int          COORD_W_DEFAULT = 11;
    localparam int          FP16_BIAS       = 15;
    localparam logic [15:0] FP16_ONE        = 16'h3C00;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SCAN
    } state_t;

endpackage

// File: rtl/int_to_fp16.sv
// Exact unsigned integer to fp16 conversion for widths up to 11 bits.
// This block is purely combinational.
module int_to_fp16
    import raster_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic [COORD_W-1:0] n,
    output logic [15:0]        f
);

    logic [3:0] e;
    logic [4:0] exp_f;
    logic [9:0] man;

    always_comb begin
        e = '0;
        for (int i = 0; i < COORD_W; i++) begin
            if (n[i]) e = 4'(i);
        end
        exp_f = 5'(FP16_BIAS) + 5'(e);
        // the leading one lands on bit 10 and drops out as the hidden bit
        man = 10'((COORD_W + 10)'(n) << (4'd10 - e));
        f = (n == '0) ? 16'h0000 : {1'b0, exp_f, man};
    end

endmodule

// File: rtl/triangle_scan.sv
// Bounding-box raster scanner feeding bayesian_coord.
// Latches a triangle, clamps its box to the screen and streams every pixel.
module triangle_scan
    import raster_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEFAULT,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               nd,
    output logic               us_rfd,
    input  logic [COORD_W-1:0] v1_x,
    input  logic [COORD_W-1:0] v1_y,
    input  logic [COORD_W-1:0] v2_x,
    input  logic [COORD_W-1:0] v2_y,
    input  logic [COORD_W-1:0] v3_x,
    input  logic [COORD_W-1:0] v3_y,
    input  logic               ds_rfd,
    output logic               rdy,
    output logic [15:0]        f1_x,
    output logic [15:0]        f1_y,
    output logic [15:0]        f2_x,
    output logic [15:0]        f2_y,
    output logic [15:0]        f3_x,
    output logic [15:0]        f3_y,
    output logic [15:0]        p_x,
    output logic [15:0]        p_y,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic               last
);

    localparam logic [COORD_W-1:0] XLIM = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] YLIM = COORD_W'(SCREEN_H - 1);

    state_t             state;
    logic               phase;
    logic [COORD_W-1:0] vx [3];
    logic [COORD_W-1:0] vy [3];
    logic [15:0]        fx [3];
    logic [15:0]        fy [3];
    logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
    logic [COORD_W-1:0] bx_lo, bx_hi, by_lo, by_hi;
    logic [COORD_W-1:0] nx, ny;
    logic [15:0]        fp_nx, fp_ny;
    logic               at_end, nlast;

    for (genvar i = 0; i < 3; i++) begin : g_vert
        int_to_fp16 #(.COORD_W(COORD_W)) u_fx (.n(vx[i]), .f(fx[i]));
        int_to_fp16 #(.COORD_W(COORD_W)) u_fy (.n(vy[i]), .f(fy[i]));
    end

    int_to_fp16 #(.COORD_W(COORD_W)) u_px (.n(nx), .f(fp_nx));
    int_to_fp16 #(.COORD_W(COORD_W)) u_py (.n(ny), .f(fp_ny));

    always_comb begin
        bx_lo = vx[0];
        bx_hi = vx[0];
        by_lo = vy[0];
        by_hi = vy[0];
        for (int i = 1; i < 3; i++) begin
            if (vx[i] < bx_lo) bx_lo = vx[i];
            if (vx[i] > bx_hi) bx_hi = vx[i];
            if (vy[i] < by_lo) by_lo = vy[i];
            if (vy[i] > by_hi) by_hi = vy[i];
        end
        if (bx_hi > XLIM) bx_hi = XLIM;
        if (by_hi > YLIM) by_hi = YLIM;
    end

    // next pixel is the box origin while in setup, else the raster successor
    always_comb begin
        at_end = (px_x == xmax) && (px_y == ymax);
        if (state == SETUP) begin
            nx = xmin;
            ny = ymin;
        end else if (px_x == xmax) begin
            nx = xmin;
            ny = px_y + 1'b1;
        end else begin
            nx = px_x + 1'b1;
            ny = px_y;
        end
        nlast = (nx == xmax) && (ny == ymax);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            phase  <= 1'b0;
            us_rfd <= 1'b0;
            rdy    <= 1'b0;
            last   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                vx[i] <= '0;
                vy[i] <= '0;
            end
            xmin <= '0;
            xmax <= '0;
            ymin <= '0;
            ymax <= '0;
            f1_x <= '0;
            f1_y <= '0;
            f2_x <= '0;
            f2_y <= '0;
            f3_x <= '0;
            f3_y <= '0;
            p_x  <= '0;
            p_y  <= '0;
            px_x <= '0;
            px_y <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    us_rfd <= 1'b1;
                    if (nd && us_rfd) begin
                        vx[0]  <= v1_x;
                        vy[0]  <= v1_y;
                        vx[1]  <= v2_x;
                        vy[1]  <= v2_y;
                        vx[2]  <= v3_x;
                        vy[2]  <= v3_y;
                        us_rfd <= 1'b0;
                        phase  <= 1'b0;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    // first pass registers the clamped box, second pass uses it
                    if (!phase) begin
                        xmin  <= bx_lo;
                        xmax  <= bx_hi;
                        ymin  <= by_lo;
                        ymax  <= by_hi;
                        phase <= 1'b1;
                    end else if (xmin > xmax || ymin > ymax) begin
                        us_rfd <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        f1_x  <= fx[0];
                        f1_y  <= fy[0];
                        f2_x  <= fx[1];
                        f2_y  <= fy[1];
                        f3_x  <= fx[2];
                        f3_y  <= fy[2];
                        px_x  <= nx;
                        px_y  <= ny;
                        p_x   <= fp_nx;
                        p_y   <= fp_ny;
                        last  <= nlast;
                        rdy   <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (ds_rfd) begin
                        if (at_end) begin
                            rdy    <= 1'b0;
                            last   <= 1'b0;
                            us_rfd <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            px_x <= nx;
                            px_y <= ny;
                            p_x  <= fp_nx;
                            p_y  <= fp_ny;
                            last <= nlast;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
